conv_tile_scheduler: RTL and testbench
======================================

// Module: conv_tile_scheduler
// PURPOSE
//  Sequences one shared MAC unit to compute the OUT_DIM x OUT_DIM valid convolution of the IN_DIM x IN_DIM
//  A matrix with the K_DIM x K_DIM B kernel. With defaults, that is 2x2 outputs c11,c12,c21,c22.
//  Sits between the top-level controller (start/done) and the computation/memory blocks.
//  Issues operand coordinates tap by tap, frames each accumulation, and hands each result to memory.
// PARAMETERS
//  IN_DIM  4  A matrix edge length (rows = cols)
//  K_DIM   3  B kernel edge length; OUT_DIM = IN_DIM-K_DIM+1 is a localparam (2)
//  IDX_W   2  coordinate width, >= clog2(IN_DIM)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset
//  start      in   1      begin a convolution; sampled only in IDLE
//  abort      in   1      synchronous cancel; return to IDLE, no done
//  busy       out  1      high in every non-IDLE state
//  done       out  1      one-cycle pulse after the last result is accepted
//  mac_valid  out  1      tap operands valid
//  mac_ready  in   1      MAC accepts the tap this cycle
//  mac_first  out  1      first tap of an output; MAC clears its accumulator
//  mac_last   out  1      last tap of an output
//  a_row,a_col out IDX_W  A coordinate = out_row+k_row, out_col+k_col
//  b_row,b_col out IDX_W  B coordinate = k_row, k_col
//  acc_valid  in   1      MAC accumulated result ready (after mac_last)
//  res_valid  out  1      result write request to memory
//  res_ready  in   1      memory accepts the write
//  res_idx    out  2      output index, row-major: 0=c11 1=c12 2=c21 3=c22
// BEHAVIOUR
//  Reset: state=IDLE; busy=done=mac_valid=mac_first=mac_last=res_valid=0; all coordinates and res_idx =0.
//  States:
//   IDLE -> ISSUE on start (abort has priority).
//   ISSUE: mac_valid=1. On mac_valid&&mac_ready, advance k_col, then k_row (row-major over K_DIM^2 taps).
//    Last tap accepted -> WAIT_ACC.
//   WAIT_ACC: all mac_* =0; on acc_valid -> WRITE.
//   WRITE: res_valid=1, res_idx=out index. On res_ready, advance out_col then out_row.
//    Next state is ISSUE, or DONE after index OUT_DIM^2-1.
//   DONE: done=1 for exactly one cycle -> IDLE.
//  Stall: mac_ready=0 holds mac_valid, coordinates, mac_first and mac_last stable (AXI-style).
//   Same rule for res_valid/res_idx while res_ready=0.
//  mac_first is high only on tap (0,0). mac_last is high only on tap (K_DIM-1,K_DIM-1).
//  acc_valid is ignored outside WAIT_ACC. res_ready is ignored outside WRITE. start is ignored while busy.
//  abort in any non-IDLE state: next cycle IDLE, counters cleared, outputs at reset values, no done.
//   abort with start in IDLE: stay IDLE.
//  Reset mid-operation: immediate return to reset values. The memory write in flight is dropped.
//  Counters are unsigned and wrap to 0 at their DIM limit. No arithmetic overflow is possible.
//  Timing with mac_ready, res_ready high and acc_valid one cycle after mac_last, start edge = cycle 0:
//   11 cycles per output (9 taps, WAIT_ACC, WRITE); done is high in cycle 45.
// STRUCTURE
//  conv_sched_pkg: state enum {IDLE,ISSUE,WAIT_ACC,WRITE,DONE}, IN_DIM/K_DIM defaults,
//   OUT_DIM function, IDX_W.
//  Sub-module tap_counter: parameterised nested row/col counter with inc/clr inputs and a wrap output.
//   Two instances: one for the kernel tap, one for the output position.
//  FSM and output decode are in this module. All outputs are registered or decoded from state only.
// TESTING
//  1 Always-ready, start pulse: 36 taps in order.
//    First tap: a(0,0) b(0,0) mac_first=1. Ninth tap: a(2,2) b(2,2) mac_last=1.
//    Tenth tap: a(0,1) b(0,0). res_idx sequence 0,1,2,3. done in cycle 45, busy cycles 1..45.
//  2 mac_ready low for 3 cycles on tap 5: a/b coordinates held stable, no tap skipped, done in cycle 48.
//  3 res_ready low for 2 cycles on res_idx=2: res_valid held, res_idx stays 2, then 3 follows.
//  4 abort during ISSUE of output 1: IDLE next cycle, busy=0, no done.
//    A new start then begins again at a(0,0).
//  5 start re-pulsed while busy and stray acc_valid in ISSUE: no effect on the sequence or on done timing.
//  6 reset low mid-WRITE: outputs at reset values immediately.
//    After release, a start gives a full correct 45-cycle run.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// Shared types and defaults for the convolution tile scheduler.
// Holds the FSM state encoding and the output-index helper.
package conv_sched_pkg;

    localparam int DEF_IN_DIM = 4;
    localparam int DEF_K_DIM  = 3;
    localparam int DEF_IDX_W  = 2;
    localparam int RES_W      = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_ACC = 3'd2,
        ST_WRITE    = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    function automatic int out_dim(input int in_dim, input int k_dim);
        return in_dim - k_dim + 1;
    endfunction

    // Row-major output index.
    function automatic logic [RES_W-1:0] out_index(input int row, input int col, input int dim);
        return RES_W'(row * dim + col);
    endfunction

endpackage

// File: rtl/conv_tile_scheduler_tap_counter.sv
// Nested row/col counter that walks a DIM x DIM grid in row-major order.
// wrap is high on the increment that steps from the last position back to (0,0).
module tap_counter #(
    parameter int DIM = 3,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] row,
    output logic [W-1:0] col,
    output logic         wrap
);

    localparam logic [W-1:0] MAX = W'(DIM - 1);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] row_q, row_d;
    logic [W-1:0] col_q, col_d;

    // NOTE: defaults first so every path assigns row_d/col_d and no latch is inferred.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (inc) begin
            if (col_q == MAX) begin
                col_d = '0;
                row_d = (row_q == MAX) ? '0 : row_q + ONE;
            end else begin
                col_d = col_q + ONE;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign wrap = inc && (row_q == MAX) && (col_q == MAX);

endmodule

// File: rtl/conv_tile_scheduler.sv
// Sequences a shared MAC through every kernel tap of every output position of a valid
// convolution, frames each accumulation and hands each result to memory.
module conv_tile_scheduler
    import conv_sched_pkg::*;
#(
    parameter int IN_DIM = DEF_IN_DIM,
    parameter int K_DIM  = DEF_K_DIM,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             mac_valid,
    input  logic             mac_ready,
    output logic             mac_first,
    output logic             mac_last,
    output logic [IDX_W-1:0] a_row,
    output logic [IDX_W-1:0] a_col,
    output logic [IDX_W-1:0] b_row,
    output logic [IDX_W-1:0] b_col,
    input  logic             acc_valid,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_idx
);

    localparam int               OUT_DIM = out_dim(IN_DIM, K_DIM);
    localparam logic [IDX_W-1:0] K_MAX   = IDX_W'(K_DIM - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] k_row, k_col, o_row, o_col;
    logic             k_inc, k_wrap, o_inc, o_wrap;

    assign k_inc = (state_q == ST_ISSUE) && mac_ready;
    assign o_inc = (state_q == ST_WRITE) && res_ready;

    tap_counter #(.DIM(K_DIM), .W(IDX_W)) u_tap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (k_inc),
        .clr   (abort),
        .row   (k_row),
        .col   (k_col),
        .wrap  (k_wrap)
    );

    tap_counter #(.DIM(OUT_DIM), .W(IDX_W)) u_out_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (o_inc),
        .clr   (abort),
        .row   (o_row),
        .col   (o_col),
        .wrap  (o_wrap)
    );

    // abort outranks every transition, including start in IDLE.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     if (start)     state_d = ST_ISSUE;
                ST_ISSUE:    if (k_wrap)    state_d = ST_WAIT_ACC;
                ST_WAIT_ACC: if (acc_valid) state_d = ST_WRITE;
                ST_WRITE:    if (o_inc)     state_d = o_wrap ? ST_DONE : ST_ISSUE;
                ST_DONE:                    state_d = ST_IDLE;
                default:                    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Outputs decode from state and counter flops only, so they hold while stalled.
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign mac_valid = (state_q == ST_ISSUE);
    assign mac_first = mac_valid && (k_row == '0) && (k_col == '0);
    assign mac_last  = mac_valid && (k_row == K_MAX) && (k_col == K_MAX);
    assign a_row     = o_row + k_row;
    assign a_col     = o_col + k_col;
    assign b_row     = k_row;
    assign b_col     = k_col;
    assign res_valid = (state_q == ST_WRITE);
    assign res_idx   = out_index(int'(o_row), int'(o_col), OUT_DIM);

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Scoreboard bench for conv_tile_scheduler: expected taps and result indices are queued
// at start, and a negedge monitor pops them on every accepted handshake.
module tb_conv_tile_scheduler;

    typedef struct packed {
        logic [1:0] ar;
        logic [1:0] ac;
        logic [1:0] br;
        logic [1:0] bc;
        logic       first;
        logic       last;
    } tap_t;

    logic       clk = 1'b0;
    logic       reset, start, abort, mac_ready, acc_valid, res_ready;
    logic       busy, done, mac_valid, mac_first, mac_last, res_valid;
    logic [1:0] a_row, a_col, b_row, b_col, res_idx;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   t0       = 0;
    bit   hold_chk_en = 1'b1;
    bit   acc_force   = 1'b0;
    tap_t exp_taps[$];
    int   exp_res[$];

    conv_tile_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .mac_valid (mac_valid),
        .mac_ready (mac_ready),
        .mac_first (mac_first),
        .mac_last  (mac_last),
        .a_row     (a_row),
        .a_col     (a_col),
        .b_row     (b_row),
        .b_col     (b_col),
        .acc_valid (acc_valid),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_idx   (res_idx)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (rel cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    function automatic logic [15:0] outs();
        return {busy, done, mac_valid, mac_first, mac_last, res_valid,
                a_row, a_col, b_row, b_col, res_idx};
    endfunction

    // MAC model: accumulated result is ready one cycle after the last tap is accepted.
    initial begin
        bit hs_last;
        acc_valid = 1'b0;
        forever begin
            @(negedge clk);
            hs_last = mac_valid && mac_ready && mac_last;
            @(posedge clk);
            #2;
            acc_valid = hs_last || acc_force;
        end
    end

    initial begin
        tap_t       cur, held_tap;
        bit         held_v = 1'b0;
        bit         held_r = 1'b0;
        logic [1:0] held_idx = '0;
        forever begin
            @(negedge clk);
            cur = '{a_row, a_col, b_row, b_col, mac_first, mac_last};
            if (hold_chk_en && held_v)
                check("mac_hold", 32'({mac_valid, cur}), 32'({1'b1, held_tap}));
            if (hold_chk_en && held_r)
                check("res_hold", 32'({res_valid, res_idx}), 32'({1'b1, held_idx}));
            held_v   = mac_valid && !mac_ready;
            held_tap = cur;
            held_r   = res_valid && !res_ready;
            held_idx = res_idx;
            if (mac_valid && mac_ready) begin
                if (exp_taps.size() == 0) check("tap_unexpected", 32'(cur), 32'hFFFF_FFFF);
                else                      check("tap", 32'(cur), 32'(exp_taps.pop_front()));
            end
            if (res_valid && res_ready) begin
                if (exp_res.size() == 0) check("res_unexpected", 32'(res_idx), 32'hFFFF_FFFF);
                else                     check("res_idx", 32'(res_idx), 32'(exp_res.pop_front()));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run();
        tap_t t;
        for (int orow = 0; orow < 2; orow++)
            for (int ocol = 0; ocol < 2; ocol++) begin
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++) begin
                        t.ar    = 2'(orow + kr);
                        t.ac    = 2'(ocol + kc);
                        t.br    = 2'(kr);
                        t.bc    = 2'(kc);
                        t.first = (kr == 0) && (kc == 0);
                        t.last  = (kr == 2) && (kc == 2);
                        exp_taps.push_back(t);
                    end
                exp_res.push_back(orow * 2 + ocol);
            end
    endtask

    task automatic flush();
        exp_taps.delete();
        exp_res.delete();
    endtask

    // Called at posedge+1; start is high for cycle 0, returns in cycle 1.
    task automatic start_run();
        push_run();
        start = 1'b1;
        t0    = cyc;
        @(negedge clk);
        check("idle_at_start", 32'(busy), 32'd0);
        next_cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_rel, input string tag);
        bit seen = 1'b0;
        int gaps = 0;
        int rel  = -1;
        while (!seen && (cyc - t0) <= exp_rel + 20) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                rel  = cyc - t0;
            end else if (!busy) begin
                gaps++;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_done_cycle"}, 32'(rel), 32'(exp_rel));
        check({tag, "_busy_gap"}, 32'(gaps), 32'd0);
        next_cycle();
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'({busy, done}), 32'd0);
        check({tag, "_taps_left"}, 32'(exp_taps.size()), 32'd0);
        check({tag, "_res_left"}, 32'(exp_res.size()), 32'd0);
    endtask

    initial begin
        int nd;
        bit got;
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        mac_ready = 1'b1;
        res_ready = 1'b1;
        #3;
        check("reset_outputs", 32'(outs()), 32'd0);
        #9;
        reset = 1'b1;

        // 1: always ready
        next_cycle();
        start_run();
        wait_done(45, "t1");

        // 2: tap 5 stalled three cycles
        next_cycle();
        start_run();
        repeat (4) next_cycle();
        mac_ready = 1'b0;
        repeat (3) next_cycle();
        mac_ready = 1'b1;
        wait_done(48, "t2");

        // 3: write of res_idx 2 stalled two cycles
        next_cycle();
        start_run();
        repeat (32) next_cycle();
        res_ready = 1'b0;
        repeat (2) next_cycle();
        res_ready = 1'b1;
        wait_done(47, "t3");

        // 4: abort during ISSUE of output 1, then a clean restart
        next_cycle();
        start_run();
        repeat (13) next_cycle();
        abort       = 1'b1;
        hold_chk_en = 1'b0;
        next_cycle();
        abort = 1'b0;
        @(negedge clk);
        check("abort_outputs", 32'(outs()), 32'd0);
        flush();
        nd = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_no_done", 32'(nd), 32'd0);
        hold_chk_en = 1'b1;
        next_cycle();
        start_run();
        wait_done(45, "t4");

        // 5: start re-pulsed while busy (including DONE), stray acc_valid in ISSUE
        next_cycle();
        start_run();
        repeat (2) next_cycle();
        start = 1'b1;
        next_cycle();
        start     = 1'b0;
        acc_force = 1'b1;
        next_cycle();
        acc_force = 1'b0;
        repeat (40) next_cycle();
        start = 1'b1;
        @(negedge clk);
        check("t5_done_cycle", 32'({done, 8'(cyc - t0)}), 32'({1'b1, 8'd45}));
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        check("t5_idle_after_done", 32'({busy, done}), 32'd0);
        check("t5_taps_left", 32'(exp_taps.size() + exp_res.size()), 32'd0);

        // 6: reset mid-WRITE, then a full run
        next_cycle();
        start_run();
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = res_valid;
        end
        check("t6_reached_write", 32'(got), 32'd1);
        #2;
        reset       = 1'b0;
        hold_chk_en = 1'b0;
        #1;
        check("t6_reset_outputs", 32'(outs()), 32'd0);
        next_cycle();
        flush();
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
        hold_chk_en = 1'b1;
        start_run();
        wait_done(45, "t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
